quad_encoder_counter: RTL and testbench

Multi-channel quadrature rotary-encoder front end. It synchronises and debounces raw A/B pins, then decodes direction in x1/x2/x4 resolution. It keeps one signed up/down position counter per channel, with per-channel clear and wrap/saturate policy. It sits between Pmod encoder pins and the display/value logic, and replaces ad-hoc per-design rotary handling.

---
 rtl/quad_encoder_counter.sv | 161 ++++++++++++++++
 tb/tb_quad_encoder_counter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_counter.sv
// rtl/quad_encoder_counter.sv - multi-channel quadrature encoder front end with debounce and position counters
module quad_encoder_counter #(
    parameter int NUM_CH         = 2,
    parameter int CNT_WIDTH      = 24,
    parameter int TICK_DIV       = 2700,
    parameter int DEBOUNCE_TICKS = 10
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_CH-1:0]             enc_a_i,
    input  logic [NUM_CH-1:0]             enc_b_i,
    input  logic [NUM_CH-1:0]             clear_i,
    input  logic [1:0]                    mode_i,
    input  logic                          sat_en_i,
    output logic [NUM_CH*CNT_WIDTH-1:0]   count_o,
    output logic [NUM_CH-1:0]             step_o,
    output logic [NUM_CH-1:0]             dir_o,
    output logic [NUM_CH-1:0]             err_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [7:0] DEB_LIMIT = 8'(DEBOUNCE_TICKS);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {1'b0, {(CNT_WIDTH-1){1'b1}}};
    localparam logic [CNT_WIDTH-1:0] CNT_MIN = {1'b1, {(CNT_WIDTH-1){1'b0}}};
    localparam int NP = 2 * NUM_CH;

    // Pins are grouped as {B[NUM_CH-1:0], A[NUM_CH-1:0]} for the debounce stage
    logic [NP-1:0]            meta_q, sync_q;
    logic [PW-1:0]            presc_q, presc_d;
    logic                     tick;
    logic [NP-1:0]            deb_q, deb_d;
    logic [NP-1:0][7:0]       stab_q, stab_d;
    logic [NUM_CH-1:0]        prev_a_q, prev_b_q;
    logic [NUM_CH-1:0]        deb_a, deb_b;
    logic [NUM_CH-1:0]        mv_en, mv_up, illegal;
    logic [NUM_CH-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0]        step_q, step_d, dir_q, dir_d, err_q, err_d;

    assign deb_a = deb_q[NUM_CH-1:0];
    assign deb_b = deb_q[NP-1:NUM_CH];
    assign tick  = (presc_q == PRESC_MAX);

    // Two-flop synchroniser; deliberately not reset so reset can seed the debouncer from live pins
    always_ff @(posedge clk_i) begin
        meta_q <= {enc_b_i, enc_a_i};
        sync_q <= meta_q;
    end

    // Shared prescaler producing the debounce sample tick
    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    // Per-pin stability counter; a level is accepted after DEBOUNCE_TICKS differing samples
    always_comb begin
        deb_d  = deb_q;
        stab_d = stab_q;
        if (tick) begin
            for (int p = 0; p < NP; p++) begin
                if (sync_q[p] == deb_q[p]) begin
                    stab_d[p] = '0;
                end else if (stab_q[p] + 8'd1 >= DEB_LIMIT) begin
                    deb_d[p]  = sync_q[p];
                    stab_d[p] = '0;
                end else begin
                    stab_d[p] = stab_q[p] + 8'd1;
                end
            end
        end
    end

    // Decode debounced transitions into step enable and direction per channel
    always_comb begin
        mv_en   = '0;
        mv_up   = '0;
        illegal = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            logic a_chg, b_chg;
            a_chg = deb_a[i] ^ prev_a_q[i];
            b_chg = deb_b[i] ^ prev_b_q[i];
            illegal[i] = a_chg & b_chg;
            case (mode_i)
                2'b00: begin
                    mv_en[i] = a_chg & ~b_chg & deb_a[i];
                    mv_up[i] = ~deb_b[i];
                end
                2'b01: begin
                    mv_en[i] = a_chg & ~b_chg;
                    mv_up[i] = deb_a[i] ^ deb_b[i];
                end
                default: begin
                    mv_en[i] = a_chg ^ b_chg;
                    mv_up[i] = a_chg ? (deb_a[i] ^ deb_b[i]) : ~(deb_a[i] ^ deb_b[i]);
                end
            endcase
        end
    end

    // Counter update with clear priority and wrap/saturate policy
    always_comb begin
        cnt_d  = cnt_q;
        step_d = '0;
        dir_d  = dir_q;
        err_d  = err_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (clear_i[i]) begin
                cnt_d[i] = '0;
                err_d[i] = 1'b0;
            end else begin
                if (illegal[i]) begin
                    err_d[i] = 1'b1;
                end
                if (mv_en[i]) begin
                    step_d[i] = 1'b1;
                    dir_d[i]  = mv_up[i];
                    if (mv_up[i]) begin
                        if (!(sat_en_i && cnt_q[i] == CNT_MAX)) begin
                            cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                        end
                    end else begin
                        if (!(sat_en_i && cnt_q[i] == CNT_MIN)) begin
                            cnt_d[i] = cnt_q[i] - CNT_WIDTH'(1);
                        end
                    end
                end
            end
        end
    end

    // State registers; debounced and previous levels reload from synced pins on reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q  <= '0;
            deb_q    <= sync_q;
            stab_q   <= '0;
            prev_a_q <= sync_q[NUM_CH-1:0];
            prev_b_q <= sync_q[NP-1:NUM_CH];
            cnt_q    <= '0;
            step_q   <= '0;
            dir_q    <= '0;
            err_q    <= '0;
        end else begin
            presc_q  <= presc_d;
            deb_q    <= deb_d;
            stab_q   <= stab_d;
            prev_a_q <= deb_a;
            prev_b_q <= deb_b;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
            err_q    <= err_d;
        end
    end

    assign count_o = cnt_q;
    assign step_o  = step_q;
    assign dir_o   = dir_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_quad_encoder_counter.sv
// tb/tb_quad_encoder_counter.sv - directed table-driven bench for quad_encoder_counter
module tb_quad_encoder_counter;

    localparam int NUM_CH = 2;
    localparam int CW     = 24;
    localparam int CWS    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] enc_a, enc_b, clear, clear_s;
    logic [1:0]        mode;
    logic              sat_en;
    logic [NUM_CH*CW-1:0]  count;
    logic [NUM_CH*CWS-1:0] count_s;
    logic [NUM_CH-1:0] step, dir, err, step_s, dir_s, err_s;

    int checks = 0;
    int errors = 0;
    int st0_tot = 0;
    int sts0_tot = 0;
    int st0_mark, sts0_mark;

    always #5 clk = ~clk;

    quad_encoder_counter #(.NUM_CH(NUM_CH), .CNT_WIDTH(CW), .TICK_DIV(4), .DEBOUNCE_TICKS(3)) u_dut (
        .clk_i(clk), .rst_i(rst), .enc_a_i(enc_a), .enc_b_i(enc_b), .clear_i(clear),
        .mode_i(mode), .sat_en_i(sat_en), .count_o(count), .step_o(step), .dir_o(dir), .err_o(err)
    );

    quad_encoder_counter #(.NUM_CH(NUM_CH), .CNT_WIDTH(CWS), .TICK_DIV(4), .DEBOUNCE_TICKS(3)) u_small (
        .clk_i(clk), .rst_i(rst), .enc_a_i(enc_a), .enc_b_i(enc_b), .clear_i(clear_s),
        .mode_i(mode), .sat_en_i(sat_en), .count_o(count_s), .step_o(step_s), .dir_o(dir_s), .err_o(err_s)
    );

    always @(posedge clk) begin
        if (step[0])   st0_tot++;
        if (step_s[0]) sts0_tot++;
    end

    typedef struct {
        logic [1:0]  ab0;
        logic [1:0]  ab1;
        logic [1:0]  md;
        logic        clr0;
        int          hold;
        logic [23:0] cnt0;
        logic [23:0] cnt1;
        logic        dir0;
        int          steps0;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic set_ab0(input logic [1:0] ab);
        enc_a[0] = ab[1];
        enc_b[0] = ab[0];
    endtask

    task automatic mark();
        st0_mark  = st0_tot;
        sts0_mark = sts0_tot;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{2'b10, 2'b01, 2'b10, 1'b0, 40, 24'h000001, 24'hFFFFFF, 1'b1, 1};
        vecs[1]  = '{2'b11, 2'b11, 2'b10, 1'b0, 40, 24'h000002, 24'hFFFFFE, 1'b1, 1};
        vecs[2]  = '{2'b01, 2'b11, 2'b10, 1'b0, 40, 24'h000003, 24'hFFFFFE, 1'b1, 1};
        vecs[3]  = '{2'b00, 2'b11, 2'b10, 1'b0, 40, 24'h000004, 24'hFFFFFE, 1'b1, 1};
        vecs[4]  = '{2'b00, 2'b11, 2'b00, 1'b1, 40, 24'h000000, 24'hFFFFFE, 1'b1, 0};
        vecs[5]  = '{2'b01, 2'b11, 2'b00, 1'b0, 40, 24'h000000, 24'hFFFFFE, 1'b1, 0};
        vecs[6]  = '{2'b11, 2'b11, 2'b00, 1'b0, 40, 24'hFFFFFF, 24'hFFFFFE, 1'b0, 1};
        vecs[7]  = '{2'b10, 2'b11, 2'b00, 1'b0, 40, 24'hFFFFFF, 24'hFFFFFE, 1'b0, 0};
        vecs[8]  = '{2'b00, 2'b11, 2'b00, 1'b0, 40, 24'hFFFFFF, 24'hFFFFFE, 1'b0, 0};
        vecs[9]  = '{2'b10, 2'b11, 2'b01, 1'b0, 40, 24'h000000, 24'hFFFFFE, 1'b1, 1};
        vecs[10] = '{2'b11, 2'b11, 2'b01, 1'b0, 40, 24'h000000, 24'hFFFFFE, 1'b1, 0};
        vecs[11] = '{2'b01, 2'b11, 2'b01, 1'b0, 40, 24'h000001, 24'hFFFFFE, 1'b1, 1};
        vecs[12] = '{2'b00, 2'b11, 2'b01, 1'b0, 40, 24'h000001, 24'hFFFFFE, 1'b1, 0};

        rst = 1'b1; enc_a = '0; enc_b = '0; clear = '0; clear_s = '0;
        mode = 2'b10; sat_en = 1'b0;
        cycles(10);
        rst = 1'b0;
        cycles(2);
        chk("reset_count", 32'(count), 32'h0);
        chk("reset_step", 32'(step), 32'h0);
        chk("reset_dir", 32'(dir), 32'h0);
        chk("reset_err", 32'(err), 32'h0);

        for (int v = 0; v < 13; v++) begin
            mode = vecs[v].md;
            set_ab0(vecs[v].ab0);
            enc_a[1] = vecs[v].ab1[1];
            enc_b[1] = vecs[v].ab1[0];
            mark();
            if (vecs[v].clr0) begin
                clear[0] = 1'b1;
                cycles(1);
                clear[0] = 1'b0;
            end
            cycles(vecs[v].hold);
            chk($sformatf("vec%0d_cnt0", v), 32'(count[0 +: CW]), 32'(vecs[v].cnt0));
            chk($sformatf("vec%0d_cnt1", v), 32'(count[CW +: CW]), 32'(vecs[v].cnt1));
            chk($sformatf("vec%0d_dir0", v), 32'(dir[0]), 32'(vecs[v].dir0));
            chk($sformatf("vec%0d_steps0", v), 32'(st0_tot - st0_mark), 32'(vecs[v].steps0));
        end

        // Glitch shorter than the debounce window is rejected
        mode = 2'b10;
        mark();
        set_ab0(2'b10); cycles(8);
        set_ab0(2'b00); cycles(40);
        chk("glitch_cnt0", 32'(count[0 +: CW]), 32'h1);
        chk("glitch_steps0", 32'(st0_tot - st0_mark), 32'h0);
        mark();
        set_ab0(2'b10); cycles(20);
        chk("accept_cnt0", 32'(count[0 +: CW]), 32'h2);
        chk("accept_steps0", 32'(st0_tot - st0_mark), 32'h1);
        cycles(20);
        chk("accept_hold_cnt0", 32'(count[0 +: CW]), 32'h2);

        // Wrap and saturate on the 4-bit instance
        clear[0] = 1'b1; clear_s[0] = 1'b1;
        cycles(1);
        clear[0] = 1'b0; clear_s[0] = 1'b0;
        cycles(5);
        chk("wrap_clr_small", 32'(count_s[0 +: CWS]), 32'h0);
        begin
            logic [1:0] seq [7];
            seq = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
            for (int s = 0; s < 7; s++) begin
                set_ab0(seq[s]);
                cycles(30);
            end
        end
        chk("up7_small", 32'(count_s[0 +: CWS]), 32'h7);
        chk("up7_big", 32'(count[0 +: CW]), 32'h7);
        set_ab0(2'b10); cycles(30);
        chk("wrap_up_small", 32'(count_s[0 +: CWS]), 32'h8);
        chk("wrap_up_big", 32'(count[0 +: CW]), 32'h8);
        set_ab0(2'b00); cycles(30);
        chk("wrap_down_small", 32'(count_s[0 +: CWS]), 32'h7);
        sat_en = 1'b1;
        mark();
        set_ab0(2'b10); cycles(30);
        chk("sat_small", 32'(count_s[0 +: CWS]), 32'h7);
        chk("sat_step_small", 32'(sts0_tot - sts0_mark), 32'h1);
        chk("sat_dir_small", 32'(dir_s[0]), 32'h1);
        chk("sat_big", 32'(count[0 +: CW]), 32'h8);
        sat_en = 1'b0;

        // Illegal double transition sets sticky err without counting
        set_ab0(2'b00); cycles(30);
        chk("pre_ill_cnt0", 32'(count[0 +: CW]), 32'h7);
        mark();
        set_ab0(2'b11); cycles(40);
        chk("ill_err0", 32'(err[0]), 32'h1);
        chk("ill_cnt0", 32'(count[0 +: CW]), 32'h7);
        chk("ill_steps0", 32'(st0_tot - st0_mark), 32'h0);
        chk("ill_err1", 32'(err[1]), 32'h0);

        // Clear held across a legal step drops the step and clears err
        mark();
        clear[0] = 1'b1;
        set_ab0(2'b01);
        cycles(40);
        clear[0] = 1'b0;
        cycles(5);
        chk("clr_cnt0", 32'(count[0 +: CW]), 32'h0);
        chk("clr_err0", 32'(err[0]), 32'h0);
        chk("clr_steps0", 32'(st0_tot - st0_mark), 32'h0);

        // Reset during debounce discards the pending level
        set_ab0(2'b11); cycles(6);
        rst = 1'b1; cycles(4);
        rst = 1'b0;
        mark();
        cycles(40);
        chk("rst_cnt0", 32'(count[0 +: CW]), 32'h0);
        chk("rst_cnt1", 32'(count[CW +: CW]), 32'h0);
        chk("rst_dir", 32'(dir), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_steps0", 32'(st0_tot - st0_mark), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
